// File: rtl/mem_vector_gather_if.sv
// Handshake and data bundle for the memory-to-vector gather stage.
// Start request, abort, memory word stream and packed vector output.
// With MEM_GATHER_VLEN_EN defined, a per-gather length input start_len is added.
interface mem_vector_gather_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int RD_W   = 5
);
  localparam int CNT_W = $clog2(LANES) + 1;

  logic                    start;
  logic [RD_W-1:0]         start_rd;
`ifdef MEM_GATHER_VLEN_EN
  logic [CNT_W-1:0]        start_len;
`endif
  logic                    abort;
  logic                    busy;

  logic                    mem_valid;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_ready;

  logic                    vec_valid;
  logic                    vec_ready;
  logic [RD_W-1:0]         vec_rd;
  logic [LANES*DATA_W-1:0] vec_data;

  // Requester / memory / consumer side
  modport master (
`ifdef MEM_GATHER_VLEN_EN
    output start_len,
`endif
    output start, start_rd, abort, mem_valid, mem_data, vec_ready,
    input  busy, mem_ready, vec_valid, vec_rd, vec_data
  );

  // Gather stage side
  modport slave (
`ifdef MEM_GATHER_VLEN_EN
    input  start_len,
`endif
    input  start, start_rd, abort, mem_valid, mem_data, vec_ready,
    output busy, mem_ready, vec_valid, vec_rd, vec_data
  );
endinterface

// File: rtl/mem_vector_gather.sv
// Memory-to-vector gather stage: packs LANES serial DATA_W-bit memory words
// into one vector and presents it with its destination register tag.
// The first accepted word always lands in lane 0. Back-to-back gathers are
// accepted in HOLD while the vector is consumed; abort wins over everything.
// Optional macro MEM_GATHER_VLEN_EN: per-gather length via start_len
// (clamped to LANES; zero length goes straight to HOLD with an all-zero vector).
module mem_vector_gather #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16,
  parameter int RD_W   = 5
) (
  input logic               clk,
  input logic               rst,
  mem_vector_gather_if.slave bus
);
  localparam int CNT_W = $clog2(LANES) + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_inc;
  logic [RD_W-1:0]         rd_q;
  logic [LANES*DATA_W-1:0] data_q;
  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        len_in;
  logic                    take_start;
  logic                    beat;

  // A new gather is accepted from IDLE, or from HOLD as the vector leaves.
  assign take_start = !bus.abort && bus.start &&
                      ((state == IDLE) || ((state == HOLD) && bus.vec_ready));
  assign beat       = bus.mem_valid && (state == COLLECT);
  assign count_inc  = count + CNT_W'(1);

`ifdef MEM_GATHER_VLEN_EN
  assign len_in = (bus.start_len > CNT_W'(LANES)) ? CNT_W'(LANES) : bus.start_len;

  // Gather length is captured together with the destination tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             len_q <= CNT_W'(LANES);
    else if (take_start) len_q <= len_in;
  end
`else
  assign len_in = CNT_W'(LANES);
  assign len_q  = CNT_W'(LANES);
`endif

  // Gather FSM: lane counter, packed data and tag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else if (bus.abort) begin
      // Partial vector left in place; it is never presented.
      state <= IDLE;
      count <= '0;
    end else if (take_start) begin
      rd_q   <= bus.start_rd;
      data_q <= '0;
      count  <= '0;
      state  <= (len_in == '0) ? HOLD : COLLECT;
    end else begin
      case (state)
        IDLE: ;
        COLLECT: begin
          if (beat) begin
            for (int i = 0; i < LANES; i++) begin
              if (count == CNT_W'(i)) data_q[i*DATA_W +: DATA_W] <= bus.mem_data;
            end
            count <= count_inc;
            if (count_inc == len_q) state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.vec_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_ready = (state == COLLECT);
  assign bus.vec_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  assign bus.vec_rd    = rd_q;
  assign bus.vec_data  = data_q;

endmodule

// File: tb/tb_mem_vector_gather.sv
// Directed bench for mem_vector_gather: full gathers, stalled stream,
// held output, back-to-back start, abort, async reset and, with
// MEM_GATHER_VLEN_EN, variable-length gathers.
module tb_mem_vector_gather;
  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int RD_W   = 5;
  localparam int W      = LANES * DATA_W;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;

  mem_vector_gather_if #(.DATA_W(DATA_W), .LANES(LANES), .RD_W(RD_W)) ifc ();

  mem_vector_gather #(.DATA_W(DATA_W), .LANES(LANES), .RD_W(RD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mkvec(input logic [15:0] base, input int n);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < n) v[i*DATA_W +: DATA_W] = base + 16'(i);
    end
    return v;
  endfunction

  task automatic do_start(input logic [RD_W-1:0] rd);
    ifc.start    = 1'b1;
    ifc.start_rd = rd;
    tick();
    ifc.start    = 1'b0;
  endtask

  // Feed words base, base+1, ... until vec_valid rises (bounded).
  task automatic feed(input string tag, input logic [15:0] base, input int n_exp,
                      input bit toggle, output int cycles);
    int beats;
    bit ph;
    bit b;
    beats  = 0;
    cycles = 0;
    ph     = 1'b1;
    while (ifc.vec_valid !== 1'b1 && cycles < 300) begin
      ifc.mem_valid = toggle ? ph : 1'b1;
      ph            = ~ph;
      ifc.mem_data  = base + 16'(beats);
      b             = ifc.mem_ready && ifc.mem_valid;
      tick();
      if (b) beats++;
      cycles++;
    end
    ifc.mem_valid = 1'b0;
    check({tag, "_vec_valid"}, W'(ifc.vec_valid), W'(1));
    check({tag, "_beats"}, W'(beats), W'(n_exp));
  endtask

  initial begin
    logic [W-1:0] held;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    ifc.start     = 1'b0;
    ifc.start_rd  = '0;
    ifc.abort     = 1'b0;
    ifc.mem_valid = 1'b0;
    ifc.mem_data  = '0;
    ifc.vec_ready = 1'b0;
`ifdef MEM_GATHER_VLEN_EN
    ifc.start_len = 5'(LANES);
`endif

    // Reset values
    #1;
    check("rst_busy", W'(ifc.busy), W'(0));
    check("rst_mem_ready", W'(ifc.mem_ready), W'(0));
    check("rst_vec_valid", W'(ifc.vec_valid), W'(0));
    check("rst_vec_rd", W'(ifc.vec_rd), W'(0));
    check("rst_vec_data", ifc.vec_data, '0);
    #21;
    rst = 1'b0;
    tick();
    check("idle_busy", W'(ifc.busy), W'(0));

    // 1: full gather, mem_valid held high, vec_ready high
    ifc.vec_ready = 1'b1;
    do_start(5'd3);
    check("t1_mem_ready", W'(ifc.mem_ready), W'(1));
    check("t1_busy", W'(ifc.busy), W'(1));
    feed("t1", 16'h0100, LANES, 1'b0, cyc);
    check("t1_latency", W'(cyc + 1), W'(17));
    check("t1_data", ifc.vec_data, mkvec(16'h0100, LANES));
    check("t1_lane0", W'(ifc.vec_data[15:0]), W'(16'h0100));
    check("t1_lane15", W'(ifc.vec_data[255:240]), W'(16'h010F));
    check("t1_rd", W'(ifc.vec_rd), W'(3));
    tick();
    check("t1_valid_one_cycle", W'(ifc.vec_valid), W'(0));
    check("t1_idle", W'(ifc.busy), W'(0));

    // 2: toggled mem_valid, consumer stalls 5 cycles
    ifc.vec_ready = 1'b0;
    do_start(5'd12);
    feed("t2", 16'h0100, LANES, 1'b1, cyc);
    held = mkvec(16'h0100, LANES);
    for (int i = 0; i < 5; i++) begin
      ifc.start    = (i == 2);
      ifc.start_rd = 5'd30;
      check("t2_hold_valid", W'(ifc.vec_valid), W'(1));
      check("t2_hold_mem_ready", W'(ifc.mem_ready), W'(0));
      check("t2_hold_data", ifc.vec_data, held);
      check("t2_hold_rd", W'(ifc.vec_rd), W'(12));
      tick();
    end
    ifc.start = 1'b0;

    // 3: back-to-back start while vector is consumed
    ifc.vec_ready = 1'b1;
    do_start(5'd7);
    check("t3_mem_ready", W'(ifc.mem_ready), W'(1));
    check("t3_vec_valid", W'(ifc.vec_valid), W'(0));
    check("t3_rd", W'(ifc.vec_rd), W'(7));
    check("t3_data_clear", ifc.vec_data, '0);

    // 4: abort after 9 beats, beat in abort cycle
    for (int i = 0; i < 9; i++) begin
      ifc.mem_valid = 1'b1;
      ifc.mem_data  = 16'h3000 + 16'(i);
      tick();
    end
    ifc.abort     = 1'b1;
    ifc.mem_valid = 1'b1;
    ifc.mem_data  = 16'hDEAD;
    tick();
    ifc.abort     = 1'b0;
    ifc.mem_valid = 1'b0;
    check("t4_busy", W'(ifc.busy), W'(0));
    check("t4_mem_ready", W'(ifc.mem_ready), W'(0));
    for (int i = 0; i < 3; i++) begin
      check("t4_no_vec_valid", W'(ifc.vec_valid), W'(0));
      tick();
    end
    do_start(5'd9);
    feed("t4", 16'h2000, LANES, 1'b0, cyc);
    check("t4_data", ifc.vec_data, mkvec(16'h2000, LANES));
    check("t4_rd", W'(ifc.vec_rd), W'(9));
    tick();
    check("t4_idle", W'(ifc.busy), W'(0));

    // 5: async reset mid-collect
    do_start(5'd21);
    for (int i = 0; i < 5; i++) begin
      ifc.mem_valid = 1'b1;
      ifc.mem_data  = 16'h5500 + 16'(i);
      tick();
    end
    ifc.mem_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("t5_busy", W'(ifc.busy), W'(0));
    check("t5_mem_ready", W'(ifc.mem_ready), W'(0));
    check("t5_vec_rd", W'(ifc.vec_rd), W'(0));
    check("t5_vec_data", ifc.vec_data, '0);
    ifc.start    = 1'b1;
    ifc.start_rd = 5'd4;
    tick();
    tick();
    check("t5_start_ignored", W'(ifc.busy), W'(0));
    ifc.start = 1'b0;
    rst       = 1'b0;
    tick();
    check("t5_after_rst", W'(ifc.busy), W'(0));

`ifdef MEM_GATHER_VLEN_EN
    // 6a: length 4
    ifc.start_len = 5'd4;
    do_start(5'd2);
    feed("t6a", 16'h00A0, 4, 1'b0, cyc);
    check("t6a_data", ifc.vec_data, mkvec(16'h00A0, 4));
    check("t6a_rd", W'(ifc.vec_rd), W'(2));
    tick();
    // 6b: length 0
    ifc.start_len = 5'd0;
    do_start(5'd6);
    check("t6b_vec_valid", W'(ifc.vec_valid), W'(1));
    check("t6b_mem_ready", W'(ifc.mem_ready), W'(0));
    check("t6b_data", ifc.vec_data, '0);
    tick();
    check("t6b_idle", W'(ifc.busy), W'(0));
    // 6c: length 20 clamps to LANES
    ifc.start_len = 5'd20;
    do_start(5'd8);
    feed("t6c", 16'h0C00, LANES, 1'b0, cyc);
    check("t6c_data", ifc.vec_data, mkvec(16'h0C00, LANES));
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_vector_gather.md
Name: mem_vector_gather

Overview:
- Parametrised memory-to-vector gather stage between the data-memory read port and the vector register file writeback.
- Accepts a serial stream of DATA_W-bit words from memory under a valid/ready handshake and packs LANES of them into one vector.
- Presents the packed vector with its destination register tag under a second valid/ready handshake.
- Supports back-to-back transfers and abort.

Parameters:
DATA_W, 16, width of one memory word / vector lane in bits
LANES, 16, lanes per vector (>=2)
RD_W, 5, width of destination register tag
CNT_W, $clog2(LANES)+1, lane counter width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request a new gather; sampled only when accepted (see Behaviour)
start_rd  input  RD_W  destination register tag for the requested gather
abort  input  1  discard the gather in progress, return to IDLE
busy  output  1  high in COLLECT or HOLD
mem_valid  input  1  memory word valid
mem_data  input  DATA_W  memory word
mem_ready  output  1  gather accepts a word this cycle
vec_valid  output  1  packed vector available
vec_ready  input  1  consumer accepts vector
vec_rd  output  RD_W  tag latched at start
vec_data  output  LANES*DATA_W  packed vector; lane i at bits [i*DATA_W +: DATA_W]

Behaviour:
- Reset (async assert, sync use after deassert): state=IDLE, count=0, busy=0, mem_ready=0, vec_valid=0, vec_rd=0, vec_data=0.
- FSM states: IDLE, COLLECT, HOLD. Outputs are registered-state decodes: mem_ready=(state==COLLECT), vec_valid=(state==HOLD), busy=(state!=IDLE).
- IDLE:
  - start=1 -> latch start_rd into vec_rd, clear vec_data to 0, count=0, go to COLLECT.
  - Otherwise hold.
- COLLECT: a beat is mem_valid&&mem_ready.
  - On a beat: lane[count]<=mem_data, count<=count+1.
  - Beat with count==LANES-1 -> HOLD.
  - No beat: hold state, data and count.
  - First word always lands in lane 0.
  - count never exceeds LANES; no wrap.
- HOLD:
  - vec_data and vec_rd held stable while vec_valid=1 && vec_ready=0.
  - vec_ready=1 && start=0 -> IDLE.
  - vec_ready=1 && start=1 -> latch new start_rd, clear vec_data, count=0, go straight to COLLECT (back-to-back, no idle bubble).
- start in COLLECT, or in HOLD without vec_ready: ignored, no queueing.
- abort=1 in any state -> IDLE next edge, count=0, vec_valid drops. vec_data keeps its last value (don't-care).
  - abort has priority over start, beats and vec handshake in the same cycle.
  - A beat coinciding with abort is consumed and discarded.
- Latency:
  - start at edge N -> mem_ready=1 from cycle N+1.
  - Last beat at edge M -> vec_valid=1 from cycle M+1.
  - Minimum start-to-vec_valid = LANES+1 cycles.
- mem_data/mem_valid are don't-care outside COLLECT; vec_ready is don't-care outside HOLD.
- rst asserted mid-gather: immediate return to reset values; partial vector lost.

Optional Feature:
- Macro: MEM_GATHER_VLEN_EN.
- With macro:
  - Adds input start_len [CNT_W-1:0], latched with start_rd.
  - Gather completes after len beats: HOLD entered on the beat with count==len-1.
  - Lanes >= len stay 0.
  - len > LANES is clamped to LANES.
  - len==0 goes IDLE -> HOLD in the cycle after start, with no mem_ready cycle and vec_data all zero.
- Without macro: port absent; length fixed at LANES.

Test Plan:
1. Defaults, start with start_rd=5'd3, feed 16 words 16'h0100..16'h010F with mem_valid held high, vec_ready=1 -> vec_valid high exactly 1 cycle, 17 cycles after start; lane0=16'h0100, lane15=16'h010F; vec_rd=3; then IDLE.
2. Same stream with mem_valid toggled 1/0 each cycle, vec_ready=0 for 5 cycles after vec_valid -> identical packing; vec_data/vec_rd stable all 5 cycles; mem_ready=0 throughout HOLD.
3. Back-to-back: in HOLD assert vec_ready=1 and start=1 with start_rd=7 -> next cycle mem_ready=1, vec_rd=7, vec_data=0, no IDLE cycle.
4. Abort after 9 beats, with mem_valid=1 in the abort cycle -> next cycle busy=0, mem_ready=0, vec_valid never asserted; a following full gather packs correctly starting at lane 0.
5. Async rst asserted mid-COLLECT, between clock edges -> outputs zero immediately; start ignored while rst=1.
6. MEM_GATHER_VLEN_EN defined:
   - start_len=4, words A,B,C,D -> vec_valid after 4 beats; lanes 0-3=A-D, lanes 4-15=0.
   - start_len=0 -> vec_valid 1 cycle after start, all-zero data.
   - start_len=20 -> 16 beats.
